// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// writeback sources, with a registered port and a contention counter.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      freeze,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic [2:0]                grant_id,
  output logic [CNT_W-1:0]          contention
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] NREQ = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  logic [PW-1:0]          rr_ptr;
  logic [2*NUM_REQ-1:0]   dbl;
  logic [NUM_REQ-1:0]     rot;
  logic                   found;
  logic [PW:0]            off;
  logic [PW:0]            sum;
  logic [PW-1:0]          gnt_idx;
  logic [ADDR_W-1:0]      sel_reg;
  logic [DATA_W-1:0]      sel_data;
  logic                   stall;

  // Rotate valids so rr_ptr sits at bit 0, then take the first set bit.
  always_comb begin
    dbl   = {req_valid, req_valid} >> rr_ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    off   = '0;
    if (!freeze) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && rot[k]) begin
          found = 1'b1;
          off   = k[PW:0];
        end
      end
    end
    sum = {1'b0, rr_ptr} + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    gnt_idx = sum[PW-1:0];
  end

  always_comb begin
    req_ready = '0;
    sel_reg   = '0;
    sel_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = found && (gnt_idx == j[PW-1:0]);
      if (found && (gnt_idx == j[PW-1:0])) begin
        sel_reg  = req_reg[j*ADDR_W +: ADDR_W];
        sel_data = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  assign stall = |(req_valid & ~req_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      grant_id   <= '0;
    end else if (found) begin
      rr_ptr     <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      RegWrite   <= (sel_reg != '0);
      write_reg  <= sel_reg;
      write_data <= sel_data;
      grant_id   <= 3'(gnt_idx);
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contention <= '0;
    end else if (stall && (contention != '1)) begin
      contention <= contention + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against
// a queue-free behavioural model of round-robin write arbitration.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_ready, req_ready4;
  logic        freeze;
  logic        RegWrite, RegWrite4;
  logic [4:0]  write_reg, write_reg4;
  logic [31:0] write_data, write_data4;
  logic [2:0]  grant_id, grant_id4;
  logic [15:0] contention;
  logic [3:0]  contention4;

  regfile_write_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .freeze(freeze),
    .RegWrite(RegWrite), .write_reg(write_reg),
    .write_data(write_data), .grant_id(grant_id),
    .contention(contention)
  );

  regfile_write_arbiter #(.CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready4), .freeze(freeze),
    .RegWrite(RegWrite4), .write_reg(write_reg4),
    .write_data(write_data4), .grant_id(grant_id4),
    .contention(contention4)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic        pv [3];
  logic [4:0]  pr [3];
  logic [31:0] pd [3];

  int          m_ptr, m_gid, m_cnt, m_cnt4;
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_gid = 0; m_cnt = 0; m_cnt4 = 0;
    m_we = 1'b0; m_reg = '0; m_data = '0;
  endtask

  task automatic drive(input logic frz);
    freeze = frz;
    for (int i = 0; i < 3; i++) begin
      req_valid[i]        = pv[i];
      req_reg[i*5 +: 5]   = pr[i];
      req_data[i*32 +: 32] = pd[i];
    end
  endtask

  task automatic check_port();
    chk("regwrite", 64'(RegWrite), 64'(m_we));
    chk("write_reg", 64'(write_reg), 64'(m_reg));
    chk("write_data", 64'(write_data), 64'(m_data));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("contention", 64'(contention), 64'(m_cnt));
    chk("contention4", 64'(contention4), 64'(m_cnt4));
  endtask

  // One clock: check the combinational grant, then the registered port.
  task automatic step(input logic frz);
    int g, idx;
    logic stall;
    logic [2:0] er;
    drive(frz);
    #2;
    g = -1;
    if (!frz) begin
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (g < 0 && pv[idx]) g = idx;
      end
    end
    er = (g < 0) ? 3'b000 : 3'(1 << g);
    chk("req_ready", 64'(req_ready), 64'(er));
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (pv[i] && i != g) stall = 1'b1;
    end
    @(posedge clock);
    if (g >= 0) begin
      m_ptr  = (g + 1) % 3;
      m_we   = (pr[g] != 0);
      m_reg  = pr[g];
      m_data = pd[g];
      m_gid  = g;
      pv[g]  = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (stall) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    #1;
    check_port();
  endtask

  task automatic set_req(input int i, input logic [4:0] r,
                         input logic [31:0] d);
    pv[i] = 1'b1; pr[i] = r; pd[i] = d;
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; pr[i] = '0; pd[i] = '0;
    end
    reset_n = 1'b0;
    drive(1'b0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_port();
    reset_n = 1'b1;

    // Build up contention, then get a live write on the port.
    set_req(0, 5'd3, 32'h11);
    step(1'b1);
    step(1'b0);
    chk("rst_pre_we", 64'(RegWrite), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_we", 64'(RegWrite), 64'd0);
    chk("rst_async_cnt", 64'(contention), 64'd0);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    set_req(0, 5'd4, 32'h22);
    step(1'b0);
    chk("rst_first_grant", 64'(grant_id), 64'd0);

    // Single write from requester 1.
    set_req(1, 5'd7, 32'h2A);
    step(1'b0);
    chk("single_reg", 64'(write_reg), 64'd7);
    chk("single_data", 64'(write_data), 64'h2A);
    chk("single_gid", 64'(grant_id), 64'd1);

    // Round robin with all three held valid.
    c0 = m_cnt;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i]) set_req(i, 5'(i + 8), 32'(n * 16 + i));
      end
      step(1'b0);
      chk("rr_order", 64'(grant_id), 64'((n + 2) % 3));
    end
    chk("rr_contention", 64'(contention - 16'(c0)), 64'd6);
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    step(1'b0);

    // Register 0 write is consumed but never enabled.
    set_req(0, 5'd0, 32'hFFFF);
    step(1'b0);
    chk("rz_we", 64'(RegWrite), 64'd0);
    set_req(0, 5'd1, 32'h5);
    set_req(1, 5'd2, 32'h6);
    set_req(2, 5'd3, 32'h7);
    step(1'b0);
    chk("rz_ptr_next", 64'(grant_id), 64'd1);
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;

    // Freeze with two requesters waiting.
    set_req(0, 5'd9, 32'hA0);
    set_req(2, 5'd10, 32'hA2);
    c0 = m_cnt;
    for (int n = 0; n < 3; n++) step(1'b1);
    chk("frz_cnt", 64'(contention - 16'(c0)), 64'd3);
    step(1'b0);
    chk("frz_release", 64'(grant_id), 64'd2);
    step(1'b0);

    // Long freeze saturates the narrow counter.
    set_req(1, 5'd12, 32'hB1);
    for (int n = 0; n < 20; n++) step(1'b1);
    chk("sat_cnt4", 64'(contention4), 64'd15);
    step(1'b0);

    // Randomized traffic, requesters holding requests until granted.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom);
        end
      end
      step($urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
